write_guard_monitor: RTL and testbench
======================================

Name: write_guard_monitor

Overview:
Parametrised successor to the single-channel memory write monitor. It checks every write request against a programmable per-module address window and raises a one-cycle-delayed block/pass verdict. Violations are queued in an alert FIFO drained with a valid/ready handshake. Repeat offenders are locked out after a programmable number of violations. The block sits between the user-area write sources (GPIO-driven or wishbone-driven) and the protected memory, with alerts routed to IO pads / LA.

Parameters:
ID_W, 2, module-ID width; NUM_MOD = 2**ID_W modules tracked
ADDR_W, 4, write address width
DATA_W, 4, write data width
FIFO_DEPTH, 4, alert FIFO entries (power of two, >=2)
CNT_W, 4, per-module violation counter width
LOCK_THRESH, 3, violations that trigger lockout (1..2**CNT_W-1)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
enforce  in  1  1 = block violating writes; 0 = monitor only (alerts still raised, wr_block stays 0)
cfg_we  in  1  write permission window for cfg_id
cfg_id  in  ID_W  module being configured
cfg_lo  in  ADDR_W  lowest permitted address (inclusive)
cfg_hi  in  ADDR_W  highest permitted address (inclusive)
wr_valid  in  1  write request present this cycle
wr_id  in  ID_W  requesting module
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_pass  out  1  registered: previous-cycle write allowed
wr_block  out  1  registered: previous-cycle write suppressed
alert_valid  out  1  FIFO non-empty
alert_ready  in  1  consumer pops head when alert_valid && alert_ready
alert_id  out  ID_W  head entry module ID
alert_addr  out  ADDR_W  head entry address
alert_data  out  DATA_W  head entry data
alert_reason  out  2  01 out-of-window, 10 module locked
locked  out  NUM_MOD  per-module lockout flags
drop_cnt  out  8  saturating count of alerts lost to FIFO full

Behaviour:
- Reset (async assert, sync-safe release): all windows lo=0, hi=all-ones; violation counters 0; locked=0; FIFO empty; wr_pass=0, wr_block=0, alert_valid=0, drop_cnt=0; alert_* fields 0.
- Check per cycle with wr_valid=1, using the table value before any same-cycle cfg_we:
  - locked[wr_id]=1 -> violation, reason 10.
  - otherwise, addr<lo or addr>hi -> violation, reason 01.
  - lo>hi means empty window: every write violates.
- Latency 1: on the edge sampling the request, wr_pass <= ~viol; wr_block <= viol & enforce. Both are 0 in cycles following wr_valid=0.
- Violation bookkeeping on the same edge:
  - Counter[wr_id] increments, saturating at 2**CNT_W-1.
  - When the incremented value equals LOCK_THRESH, locked[wr_id] sets.
  - Locked-module writes also count toward the counter.
- cfg_we=1: writes lo/hi for cfg_id, clears counter[cfg_id] and locked[cfg_id].
  - If a violation by the same id occurs in that cycle, cfg wins: counter and lock end at 0. The alert is still pushed.
- Alert FIFO:
  - A violation pushes {id, addr, data, reason}; alert_valid rises the cycle after the violating request.
  - Head is presented combinationally from storage (first-word fall-through).
  - Pop occurs on edges where alert_valid && alert_ready.
  - Full + push + pop in the same cycle: both succeed, occupancy unchanged.
  - Full + push without pop: entry dropped, drop_cnt++ (saturates at 255).
  - Empty + alert_ready: no effect.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is ID-independent.
- enforce affects only wr_block; counters, locks and alerts operate identically in both modes.
- Reset mid-operation: FIFO contents discarded, tables reverted, outputs at reset values immediately (async).

Test Plan:
- Reset, then write id=0 addr=0xF data=0xA -> next cycle wr_pass=1, wr_block=0, alert_valid=0.
- cfg id=1 lo=4 hi=7; enforce=1; write id=1 addr=8 data=3 -> next cycle wr_block=1, alert_valid=1, head {1,8,3,01}; pop -> alert_valid=0.
- Same window, three violating writes id=1, then write id=1 addr=5 -> locked[1]=1 after third; fourth blocked with reason 10; cfg id=1 -> locked[1]=0, next addr=5 passes.
- enforce=0, write id=2 addr=2 with window lo=8 hi=9 -> wr_block=0, wr_pass=0, alert pushed, reason 01.
- alert_ready=0, six violations with FIFO_DEPTH=4 -> 4 entries held in order, drop_cnt=2; then one violation with alert_ready=1 while full -> occupancy stays 4, drop_cnt stays 2.
- Assert rst_n low with 3 queued alerts and locked[1]=1 -> alert_valid=0, locked=0, drop_cnt=0 immediately; after release, write id=1 addr=0 passes.

Source files
------------

// File: rtl/write_guard_monitor_if.sv
// Write request and alert drain bundle for write_guard_monitor.
// master = write source / alert consumer, slave = monitor.
interface write_guard_monitor_if #(
  parameter int ID_W   = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              wr_valid;
  logic [ID_W-1:0]   wr_id;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              alert_valid;
  logic              alert_ready;
  logic [ID_W-1:0]   alert_id;
  logic [ADDR_W-1:0] alert_addr;
  logic [DATA_W-1:0] alert_data;
  logic [1:0]        alert_reason;

  modport master (
    output wr_valid, wr_id, wr_addr, wr_data,
    output alert_ready,
    input  alert_valid, alert_id, alert_addr,
    input  alert_data, alert_reason
  );

  modport slave (
    input  wr_valid, wr_id, wr_addr, wr_data,
    input  alert_ready,
    output alert_valid, alert_id, alert_addr,
    output alert_data, alert_reason
  );
endinterface

// File: rtl/write_guard_monitor.sv
// Per-module address window guard with lockout and
// a first-word fall-through alert FIFO.
module write_guard_monitor #(
  parameter int ID_W        = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 4,
  parameter int LOCK_THRESH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enforce,
  input  logic                   cfg_we,
  input  logic [ID_W-1:0]        cfg_id,
  input  logic [ADDR_W-1:0]      cfg_lo,
  input  logic [ADDR_W-1:0]      cfg_hi,
  write_guard_monitor_if.slave   bus,
  output logic                   wr_pass,
  output logic                   wr_block,
  output logic [(1<<ID_W)-1:0]   locked,
  output logic [7:0]             drop_cnt
);
  localparam int NUM_MOD = 1 << ID_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        reason;
  } alert_t;

  logic [ADDR_W-1:0]  lo_q [NUM_MOD];
  logic [ADDR_W-1:0]  lo_d [NUM_MOD];
  logic [ADDR_W-1:0]  hi_q [NUM_MOD];
  logic [ADDR_W-1:0]  hi_d [NUM_MOD];
  logic [CNT_W-1:0]   cnt_q [NUM_MOD];
  logic [CNT_W-1:0]   cnt_d [NUM_MOD];
  logic [NUM_MOD-1:0] lock_q, lock_d;
  alert_t             mem_q [FIFO_DEPTH];
  alert_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [7:0]         drop_q, drop_d;
  logic               pass_q, pass_d;
  logic               block_q, block_d;

  logic               lock_hit, oow, viol;
  logic               full, pop, push_ok;
  logic [CNT_W-1:0]   inc;
  alert_t             entry, head;

  always_comb begin
    lock_hit = lock_q[bus.wr_id];
    // lo>hi needs no special case: any addr is <lo or >hi
    oow = (bus.wr_addr < lo_q[bus.wr_id]) ||
          (bus.wr_addr > hi_q[bus.wr_id]);
    viol = bus.wr_valid && (lock_hit || oow);
    entry.id     = bus.wr_id;
    entry.addr   = bus.wr_addr;
    entry.data   = bus.wr_data;
    entry.reason = lock_hit ? 2'b10 : 2'b01;
    inc = (cnt_q[bus.wr_id] == '1) ? cnt_q[bus.wr_id]
                                   : cnt_q[bus.wr_id] + 1'b1;
    pass_d  = bus.wr_valid && !viol;
    block_d = viol && enforce;

    lo_d   = lo_q;
    hi_d   = hi_q;
    cnt_d  = cnt_q;
    lock_d = lock_q;
    for (int i = 0; i < NUM_MOD; i++) begin
      if (viol && bus.wr_id == ID_W'(i)) begin
        cnt_d[i] = inc;
        if (inc == CNT_W'(LOCK_THRESH)) lock_d[i] = 1'b1;
      end
      // reconfiguration overrides same-cycle bookkeeping
      if (cfg_we && cfg_id == ID_W'(i)) begin
        lo_d[i]   = cfg_lo;
        hi_d[i]   = cfg_hi;
        cnt_d[i]  = '0;
        lock_d[i] = 1'b0;
      end
    end

    full    = occ_q == OCC_W'(FIFO_DEPTH);
    pop     = (occ_q != '0) && bus.alert_ready;
    push_ok = viol && (!full || pop);
    mem_d   = mem_q;
    if (push_ok) mem_d[wp_q] = entry;
    wp_d  = push_ok ? wp_q + 1'b1 : wp_q;
    rp_d  = pop ? rp_q + 1'b1 : rp_q;
    occ_d = occ_q + OCC_W'(push_ok) - OCC_W'(pop);
    drop_d = drop_q;
    if (viol && full && !pop && drop_q != 8'hff)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MOD; i++) begin
        lo_q[i]  <= '0;
        hi_q[i]  <= '1;
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      lock_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      occ_q   <= '0;
      drop_q  <= '0;
      pass_q  <= 1'b0;
      block_q <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      lock_q  <= lock_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
      drop_q  <= drop_d;
      pass_q  <= pass_d;
      block_q <= block_d;
    end
  end

  assign head             = mem_q[rp_q];
  assign bus.alert_valid  = occ_q != '0;
  assign bus.alert_id     = bus.alert_valid ? head.id : '0;
  assign bus.alert_addr   = bus.alert_valid ? head.addr : '0;
  assign bus.alert_data   = bus.alert_valid ? head.data : '0;
  assign bus.alert_reason = bus.alert_valid ? head.reason : '0;
  assign wr_pass          = pass_q;
  assign wr_block         = block_q;
  assign locked           = lock_q;
  assign drop_cnt         = drop_q;
endmodule

// File: tb/tb_write_guard_monitor.sv
// Scoreboard bench for write_guard_monitor.
// Expected alert heads are queued at drive time.
module tb_write_guard_monitor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enforce = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_id = '0;
  logic [3:0] cfg_lo = '0;
  logic [3:0] cfg_hi = '0;
  logic       wr_pass, wr_block;
  logic [3:0] locked;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [11:0] sb [$];

  write_guard_monitor_if #(.ID_W(2), .ADDR_W(4), .DATA_W(4)) bus ();

  write_guard_monitor #(
    .ID_W(2), .ADDR_W(4), .DATA_W(4),
    .FIFO_DEPTH(4), .CNT_W(4), .LOCK_THRESH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enforce(enforce),
    .cfg_we(cfg_we), .cfg_id(cfg_id),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .bus(bus),
    .wr_pass(wr_pass), .wr_block(wr_block),
    .locked(locked), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] id,
                     input logic [3:0] lo, input logic [3:0] hi);
    cfg_we = 1'b1; cfg_id = id; cfg_lo = lo; cfg_hi = hi;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] id,
                    input logic [3:0] addr, input logic [3:0] data);
    bus.wr_valid = 1'b1; bus.wr_id = id;
    bus.wr_addr = addr; bus.wr_data = data;
    cycle();
    bus.wr_valid = 1'b0;
  endtask

  function automatic logic [11:0] mk(input logic [1:0] id,
      input logic [3:0] a, input logic [3:0] d, input logic [1:0] r);
    return {id, a, d, r};
  endfunction

  function automatic logic [11:0] head();
    return {bus.alert_id, bus.alert_addr,
            bus.alert_data, bus.alert_reason};
  endfunction

  task automatic pop_head(output logic [11:0] got, output bit ok);
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (bus.alert_valid) ok = 1'b1;
      else cycle();
    end
    if (ok) begin
      got = head();
      bus.alert_ready = 1'b1;
      cycle();
      bus.alert_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({wr_pass, wr_block, bus.alert_valid, locked, drop_cnt,
         head()} !== '0) begin
      failures++;
      $display("FAIL reset_state: got pass=%b blk=%b av=%b lk=%h dc=%0d hd=%h want all 0",
               wr_pass, wr_block, bus.alert_valid, locked, drop_cnt, head());
    end
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    wr(2'd0, 4'hF, 4'hA);
    checks++;
    if ({wr_pass, wr_block, bus.alert_valid} !== 3'b100) begin
      failures++;
      $display("FAIL default_window: got pass/blk/av=%b%b%b want 100",
               wr_pass, wr_block, bus.alert_valid);
    end
    cycle();
    checks++;
    if ({wr_pass, wr_block} !== 2'b00) begin
      failures++;
      $display("FAIL idle_outputs: got pass/blk=%b%b want 00",
               wr_pass, wr_block);
    end
  endtask

  task automatic test_window();
    logic [11:0] got, exp;
    bit ok;
    enforce = 1'b1;
    cfg(2'd1, 4'd4, 4'd7);
    wr(2'd1, 4'd4, 4'd0);
    checks++;
    if (wr_pass !== 1'b1) begin
      failures++;
      $display("FAIL lo_edge_pass: got %b want 1", wr_pass);
    end
    wr(2'd1, 4'd7, 4'd0);
    checks++;
    if (wr_pass !== 1'b1 || bus.alert_valid !== 1'b0) begin
      failures++;
      $display("FAIL hi_edge_pass: got pass=%b av=%b want 1 0",
               wr_pass, bus.alert_valid);
    end
    wr(2'd1, 4'd8, 4'd3);
    sb.push_back(mk(2'd1, 4'd8, 4'd3, 2'b01));
    checks++;
    if ({wr_pass, wr_block, bus.alert_valid} !== 3'b011) begin
      failures++;
      $display("FAIL oow_block: got pass/blk/av=%b%b%b want 011",
               wr_pass, wr_block, bus.alert_valid);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      pop_head(got, ok);
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        $display("FAIL window_head: got %h ok=%0d want %h", got, ok, exp);
      end
    end
    checks++;
    if (bus.alert_valid !== 1'b0) begin
      failures++;
      $display("FAIL pop_empty: got av=%b want 0", bus.alert_valid);
    end
  endtask

  task automatic test_lockout();
    logic [11:0] got, exp;
    bit ok;
    enforce = 1'b1;
    cfg(2'd1, 4'd4, 4'd7);
    wr(2'd1, 4'd0, 4'd1);
    wr(2'd1, 4'd9, 4'd2);
    checks++;
    if (locked !== 4'b0000) begin
      failures++;
      $display("FAIL early_lock: got %b want 0000", locked);
    end
    wr(2'd1, 4'd15, 4'd3);
    checks++;
    if (locked !== 4'b0010) begin
      failures++;
      $display("FAIL lock_third: got %b want 0010", locked);
    end
    wr(2'd1, 4'd5, 4'd4);
    checks++;
    if ({wr_pass, wr_block} !== 2'b01) begin
      failures++;
      $display("FAIL locked_block: got pass/blk=%b%b want 01",
               wr_pass, wr_block);
    end
    sb.push_back(mk(2'd1, 4'd0, 4'd1, 2'b01));
    sb.push_back(mk(2'd1, 4'd9, 4'd2, 2'b01));
    sb.push_back(mk(2'd1, 4'd15, 4'd3, 2'b01));
    sb.push_back(mk(2'd1, 4'd5, 4'd4, 2'b10));
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      pop_head(got, ok);
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        $display("FAIL lock_head: got %h ok=%0d want %h", got, ok, exp);
      end
    end
    cfg(2'd1, 4'd4, 4'd7);
    checks++;
    if (locked !== 4'b0000) begin
      failures++;
      $display("FAIL cfg_unlock: got %b want 0000", locked);
    end
    wr(2'd1, 4'd5, 4'd0);
    checks++;
    if (wr_pass !== 1'b1) begin
      failures++;
      $display("FAIL unlock_pass: got %b want 1", wr_pass);
    end
    wr(2'd1, 4'd0, 4'd1);
    wr(2'd1, 4'd9, 4'd2);
    // third violation lands with a cfg for the same id
    cfg_we = 1'b1; cfg_id = 2'd1; cfg_lo = 4'd0; cfg_hi = 4'd15;
    wr(2'd1, 4'd9, 4'd3);
    cfg_we = 1'b0;
    checks++;
    if (wr_block !== 1'b1 || locked !== 4'b0000) begin
      failures++;
      $display("FAIL cfg_wins: got blk=%b lk=%b want 1 0000",
               wr_block, locked);
    end
    wr(2'd1, 4'd9, 4'd4);
    checks++;
    if (wr_pass !== 1'b1) begin
      failures++;
      $display("FAIL new_window: got %b want 1", wr_pass);
    end
    sb.push_back(mk(2'd1, 4'd0, 4'd1, 2'b01));
    sb.push_back(mk(2'd1, 4'd9, 4'd2, 2'b01));
    sb.push_back(mk(2'd1, 4'd9, 4'd3, 2'b01));
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      pop_head(got, ok);
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        $display("FAIL cfgwin_head: got %h ok=%0d want %h", got, ok, exp);
      end
    end
  endtask

  task automatic test_monitor();
    logic [11:0] got, exp;
    bit ok;
    enforce = 1'b0;
    cfg(2'd2, 4'd8, 4'd9);
    wr(2'd2, 4'd2, 4'd5);
    sb.push_back(mk(2'd2, 4'd2, 4'd5, 2'b01));
    checks++;
    if ({wr_pass, wr_block, bus.alert_valid} !== 3'b001) begin
      failures++;
      $display("FAIL monitor_only: got pass/blk/av=%b%b%b want 001",
               wr_pass, wr_block, bus.alert_valid);
    end
    cfg(2'd3, 4'd9, 4'd8);
    wr(2'd3, 4'd8, 4'd1);
    sb.push_back(mk(2'd3, 4'd8, 4'd1, 2'b01));
    checks++;
    if ({wr_pass, wr_block} !== 2'b00) begin
      failures++;
      $display("FAIL empty_window: got pass/blk=%b%b want 00",
               wr_pass, wr_block);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      pop_head(got, ok);
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        $display("FAIL monitor_head: got %h ok=%0d want %h", got, ok, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] got, exp;
    bit ok;
    enforce = 1'b1;
    bus.alert_ready = 1'b0;
    cfg(2'd2, 4'd8, 4'd9);
    for (int k = 0; k < 6; k++) begin
      wr(2'd2, 4'(k), 4'(k));
      if (k < 4)
        sb.push_back(mk(2'd2, 4'(k), 4'(k), (k < 3) ? 2'b01 : 2'b10));
    end
    checks++;
    if (drop_cnt !== 8'd2 || locked !== 4'b0100) begin
      failures++;
      $display("FAIL overflow_drop: got dc=%0d lk=%b want 2 0100",
               drop_cnt, locked);
    end
    exp = sb.pop_front();
    got = head();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL full_head: got %h want %h", got, exp);
    end
    bus.alert_ready = 1'b1;
    wr(2'd2, 4'd6, 4'd6);
    bus.alert_ready = 1'b0;
    sb.push_back(mk(2'd2, 4'd6, 4'd6, 2'b10));
    checks++;
    if (drop_cnt !== 8'd2 || bus.alert_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_push_pop: got dc=%0d av=%b want 2 1",
               drop_cnt, bus.alert_valid);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      pop_head(got, ok);
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        $display("FAIL order_head: got %h ok=%0d want %h", got, ok, exp);
      end
    end
    checks++;
    if (bus.alert_valid !== 1'b0) begin
      failures++;
      $display("FAIL occupancy: got av=%b after 4 pops want 0",
               bus.alert_valid);
    end
  endtask

  task automatic test_reset_mid();
    cfg(2'd1, 4'd4, 4'd7);
    wr(2'd1, 4'd0, 4'd1);
    wr(2'd1, 4'd8, 4'd2);
    wr(2'd1, 4'd9, 4'd3);
    checks++;
    if (locked !== 4'b0110 || bus.alert_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got lk=%b av=%b want 0110 1",
               locked, bus.alert_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.alert_valid !== 1'b0 || locked !== 4'b0000 ||
        drop_cnt !== 8'd0 || wr_pass !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got av=%b lk=%b dc=%0d pass=%b want 0 0 0 0",
               bus.alert_valid, locked, drop_cnt, wr_pass);
    end
    sb.delete();
    cycle();
    rst_n = 1'b1;
    cycle();
    wr(2'd1, 4'd0, 4'd0);
    checks++;
    if (wr_pass !== 1'b1 || bus.alert_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got pass=%b av=%b want 1 0",
               wr_pass, bus.alert_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_id = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.alert_ready = 1'b0;
    test_reset();
    test_window();
    test_lockout();
    test_monitor();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
